axi_stream_input: RTL and testbench

- AXI4-Stream slave that receives one CHAR_LEN-bit character per beat from the host DMA and buffers the beats, with TLAST, in an on-chip FIFO.
- When the training datapath requests data, the block drains the FIFO and assembles N characters into one parallel word (N*CHAR_LEN bits).
- It is the ingress counterpart of the training core's stream output path.
- It also checks TLAST placement against the batch length.

---
 rtl/axi_stream_input_pkg.sv | 18 +
 rtl/axi_stream_input_fifo.sv | 49 ++++
 rtl/axi_stream_input.sv | 75 +++++++
 tb/tb_axi_stream_input.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_input_pkg.sv
// axi_stream_input_pkg: training-core constants shared by the stream ingress path.
package axi_stream_input_pkg;

    localparam int CHAR_LEN   = 8;
    localparam int N          = 10;
    localparam int BATCH_SIZE = 64;
    localparam int STATE_LEN  = 3;

    typedef logic [STATE_LEN-1:0] state_t;

    localparam logic [STATE_LEN-1:0] M_FIN = 3'd4;

    // Index of the beat that must carry TLAST within a batch.
    function automatic int last_beat(input int batch, input int n);
        return batch * n - 1;
    endfunction

endpackage

// File: rtl/axi_stream_input_fifo.sv
// axi_stream_input_fifo: generic first-word-fall-through FIFO; data_r is valid whenever empty is low.
module axi_stream_input_fifo #(
    parameter int WIDTH    = 9,
    parameter int SIZE     = 1024,
    parameter int LOG_SIZE = 10
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             we,
    input  logic [WIDTH-1:0] data,
    input  logic             re,
    output logic [WIDTH-1:0] data_r,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0]    mem [SIZE];
    logic [LOG_SIZE-1:0] wr_ptr, rd_ptr;
    logic [LOG_SIZE:0]   used;
    logic                push, pop;

    assign push   = we & ~full;
    assign pop    = re & ~empty;
    assign empty  = used == '0;
    assign full   = used == (LOG_SIZE + 1)'(SIZE);
    assign data_r = mem[rd_ptr];

    function automatic logic [LOG_SIZE-1:0] nxt(input logic [LOG_SIZE-1:0] p);
        return (p == LOG_SIZE'(SIZE - 1)) ? '0 : p + LOG_SIZE'(1);
    endfunction

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= data;
    end

    // Storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            used <= used + {{LOG_SIZE{1'b0}}, push} - {{LOG_SIZE{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/axi_stream_input.sv
// axi_stream_input: AXI4-Stream slave that buffers characters with TLAST in a FIFO,
// assembles N-character words on request and flags misplaced TLAST beats.
module axi_stream_input
    import axi_stream_input_pkg::*;
#(
    parameter int CHAR_LEN   = axi_stream_input_pkg::CHAR_LEN,
    parameter int N          = axi_stream_input_pkg::N,
    parameter int BATCH_SIZE = axi_stream_input_pkg::BATCH_SIZE,
    parameter int FIFO_SIZE  = 1024,
    parameter int LOG_SIZE   = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [CHAR_LEN-1:0]   S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  run,
    input  state_t                state,
    output logic [N*CHAR_LEN-1:0] q,
    output logic                  valid,
    output logic                  last_err
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]       FULL_CNT = CW'(N);
    localparam logic [LOG_SIZE-1:0] LAST_IDX = LOG_SIZE'(last_beat(BATCH_SIZE, N));

    logic                fifo_full, fifo_empty, fifo_we, fifo_re, exp_last, fin;
    logic [CHAR_LEN:0]   data_r;
    logic [CW-1:0]       count1;
    logic [LOG_SIZE-1:0] count2;

    // Held low while in reset so the master sees no readiness until release.
    assign S_AXIS_TREADY = ARESETN & ~fifo_full;
    assign fifo_we       = S_AXIS_TVALID & S_AXIS_TREADY;
    assign fifo_re       = run & ~fifo_empty & (count1 != FULL_CNT);
    assign valid         = count1 == FULL_CNT;
    assign exp_last      = count2 == LAST_IDX;
    assign fin           = state == M_FIN;

    axi_stream_input_fifo #(
        .WIDTH   (CHAR_LEN + 1),
        .SIZE    (FIFO_SIZE),
        .LOG_SIZE(LOG_SIZE)
    ) u_fifo (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .we     (fifo_we),
        .data   ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .re     (fifo_re),
        .data_r (data_r),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q        <= '0;
            count1   <= '0;
            count2   <= '0;
            last_err <= 1'b0;
        end else begin
            if (fifo_re) q[count1*CHAR_LEN +: CHAR_LEN] <= data_r[CHAR_LEN-1:0];
            if (!run) count1 <= '0;
            else if (fifo_re) count1 <= count1 + CW'(1);
            // Batch end clears tracking even if a pop lands in the same cycle.
            if (fin) count2 <= '0;
            else if (fifo_re) count2 <= count2 + LOG_SIZE'(1);
            if (fin) last_err <= 1'b0;
            else if (fifo_re && (data_r[CHAR_LEN] != exp_last)) last_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_stream_input.sv
// tb_axi_stream_input: scoreboard bench; accepted beats build expected words that are
// compared whenever valid rises.
module tb_axi_stream_input;
    import axi_stream_input_pkg::*;

    localparam int W = N * CHAR_LEN;

    logic                ACLK = 1'b0, ARESETN = 1'b1;
    logic                tvalid = 1'b0, tlast = 1'b0, run = 1'b0;
    logic [CHAR_LEN-1:0] tdata = '0;
    state_t              state = '0;
    logic                tready, valid, last_err;
    logic [W-1:0]        q;

    logic [CHAR_LEN-1:0] chars[$];
    logic [W-1:0]        sb[$];
    int                  checks = 0, errors = 0, words = 0, words0;
    logic                vprev = 1'b0;

    axi_stream_input dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXIS_TDATA (tdata),
        .S_AXIS_TLAST (tlast),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .run          (run),
        .state        (state),
        .q            (q),
        .valid        (valid),
        .last_err     (last_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [CHAR_LEN-1:0] d);
        logic [W-1:0] w;
        chars.push_back(d);
        if (chars.size() == N) begin
            w = '0;
            for (int i = 0; i < N; i++) w[i*CHAR_LEN +: CHAR_LEN] = chars[i];
            sb.push_back(w);
            chars.delete();
        end
    endtask

    // Called at a negedge; returns just after the edge that accepted the beat.
    task automatic send(input logic [CHAR_LEN-1:0] d, input logic l);
        logic ok;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        for (int i = 0; i < 100; i++) begin
            ok = tready;
            @(posedge ACLK);
            if (ok) begin
                accept(d);
                return;
            end
            @(negedge ACLK);
        end
        tvalid = 1'b0;
        chk("accept_timeout", tready, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (valid) return;
        end
        chk("valid_timeout", valid, 1);
    endtask

    task automatic mfin();
        @(negedge ACLK);
        state = M_FIN;
        @(negedge ACLK);
        state = '0;
    endtask

    always @(negedge ACLK) begin
        if (!ARESETN) vprev <= 1'b0;
        else begin
            if (valid && !vprev) begin
                words <= words + 1;
                if (sb.size() == 0) chk("spurious_valid", valid, 0);
                else chk("word", q, sb.pop_front());
            end
            vprev <= valid;
        end
    end

    initial begin
        #3 ARESETN = 1'b0;
        #3;
        chk("rst_tready", tready, 0);
        chk("rst_q", q, 0);
        chk("rst_valid", valid, 0);
        chk("rst_lerr", last_err, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("tready_after_rst", tready, 1);

        // Basic word with exact latency
        run = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge ACLK);
            chk("tready_basic", tready, 1);
            send(CHAR_LEN'(k + 1), 1'b0);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        chk("valid_early", valid, 0);
        @(negedge ACLK);
        chk("valid_at_n", valid, 1);
        chk("basic_q", q, 80'h0A090807060504030201);

        // Run handshake
        @(negedge ACLK);
        run = 1'b0;
        @(negedge ACLK);
        chk("valid_drop", valid, 0);
        chk("q_stale", q, 80'h0A090807060504030201);
        run = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge ACLK);
            send(CHAR_LEN'(8'h11 + k), 1'b0);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        wait_valid();
        chk("hs_slot0", q[CHAR_LEN-1:0], 8'h11);
        run = 1'b0;
        mfin();

        // Backpressure plus a full batch with TLAST on its final beat
        for (int i = 0; i < 1024; i++) begin
            @(negedge ACLK);
            send(CHAR_LEN'(i), i == last_beat(BATCH_SIZE, N));
        end
        @(negedge ACLK);
        tvalid = 1'b1;
        tdata  = CHAR_LEN'(1024);
        tlast  = 1'b0;
        chk("full_tready", tready, 0);
        @(negedge ACLK);
        chk("full_tready_hold", tready, 0);
        words0 = words;
        run = 1'b1;
        send(CHAR_LEN'(1024), 1'b0);
        for (int i = 1025; i < 1030; i++) begin
            @(negedge ACLK);
            send(CHAR_LEN'(i), 1'b0);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        for (int w = 0; w < 103; w++) begin
            wait_valid();
            run = 1'b0;
            @(negedge ACLK);
            run = 1'b1;
        end
        @(negedge ACLK);
        chk("bp_words", words - words0, 103);
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_lerr", last_err, 0);
        chk("bp_tready", tready, 1);
        mfin();

        // Misplaced TLAST on beat 5
        for (int k = 0; k < N; k++) begin
            @(negedge ACLK);
            chk("lerr_progress", last_err, k >= 7);
            send(CHAR_LEN'(8'h30 + k), k == 5);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        wait_valid();
        chk("lerr_sticky", last_err, 1);
        mfin();
        chk("lerr_fin_clear", last_err, 0);

        // Asynchronous reset mid-word
        run = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge ACLK);
            send(CHAR_LEN'(8'hC0 + k), 1'b0);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        run = 1'b1;
        repeat (4) @(posedge ACLK);
        #2;
        chk("pre_rst_q", q[31:0], 32'hC3C2C1C0);
        ARESETN = 1'b0;
        chars.delete();
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_tready", tready, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge ACLK);
            send(CHAR_LEN'(8'hA0 + k), 1'b0);
        end
        @(negedge ACLK);
        tvalid = 1'b0;
        wait_valid();
        chk("post_rst_q", q, 80'hA9A8A7A6A5A4A3A2A1A0);
        chk("post_rst_lerr", last_err, 0);
        @(negedge ACLK);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
